// File: rtl/rgb_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pixel_packer
// Purpose  : Serialises one 12-bit RGB444 pixel per handshake into three
//            consecutive 4-bit writes (R, G, B) with a write strobe, and tracks
//            the raster position so the downstream averaging stage stays
//            frame-aligned.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH      pixels per row  (1..511)
//   HEIGHT     rows per frame  (1..511)
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   pix_valid  in   upstream pixel available
//   pix_rgb    in   [11:0] pixel, R=[11:8] G=[7:4] B=[3:0]
//   pix_ready  out  pixel can be accepted this cycle (combinational)
//   hold       in   downstream stall, freezes the serialiser
//   wr_en      out  data_out valid this cycle
//   data_out   out  [3:0] current nibble
//   col, row   out  [8:0] position of the pixel being serialised
//   frame_done out  one-cycle pulse after the last B nibble of a frame
//   checksum   out  [15:0] per-frame nibble sum (only with PACKER_CHECKSUM_EN)
// Build option:
//   PACKER_CHECKSUM_EN  adds the checksum port and its accumulator
// ============================================================================
module rgb_pixel_packer #(
   parameter int WIDTH  = 400,
   parameter int HEIGHT = 300
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_valid,
   input  logic [11:0] pix_rgb,
   output logic        pix_ready,
   input  logic        hold,
   output logic        wr_en,
   output logic [3:0]  data_out,
   output logic [8:0]  col,
   output logic [8:0]  row,
   output logic        frame_done
`ifdef PACKER_CHECKSUM_EN
   ,
   output logic [15:0] checksum
`endif
);

   localparam logic [8:0] c_LAST_COL = 9'(WIDTH - 1);
   localparam logic [8:0] c_LAST_ROW = 9'(HEIGHT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEND_R = 2'd1,
      ST_SEND_G = 2'd2,
      ST_SEND_B = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   // The R nibble is loaded straight into data_out on the accept edge, so
   // only G and B need to be kept for the following two cycles.
   logic [7:0]  r_gb;
   logic [3:0]  r_data;
   logic [3:0]  w_data_nxt;
   logic [8:0]  r_col;
   logic [8:0]  r_row;
   logic [8:0]  w_col_nxt;
   logic [8:0]  w_row_nxt;
   logic        r_frame_done;
   logic        w_wrap_frame;
   logic        w_accept;
   logic        w_advance;

   assign pix_ready = !hold && !reset &&
                      ((r_state == ST_IDLE) || (r_state == ST_SEND_B));
   assign w_accept  = pix_valid && pix_ready;
   assign w_advance = (r_state == ST_SEND_B) && !hold;

   // wr_en follows the registered state; a stall masks it without
   // disturbing the pending nibble.
   assign wr_en      = (r_state != ST_IDLE) && !hold;
   assign data_out   = r_data;
   assign col        = r_col;
   assign row        = r_row;
   assign frame_done = r_frame_done && !hold;

   // Next state and next nibble
   always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = r_data;
      if (!hold) begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  w_state_nxt = ST_SEND_R;
                  w_data_nxt  = pix_rgb[11:8];
               end
            end
            ST_SEND_R: begin
               w_state_nxt = ST_SEND_G;
               w_data_nxt  = r_gb[7:4];
            end
            ST_SEND_G: begin
               w_state_nxt = ST_SEND_B;
               w_data_nxt  = r_gb[3:0];
            end
            ST_SEND_B: begin
               if (w_accept) begin
                  w_state_nxt = ST_SEND_R;
                  w_data_nxt  = pix_rgb[11:8];
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Raster position: advances once per pixel, on its B nibble
   always_comb begin
      w_col_nxt    = r_col;
      w_row_nxt    = r_row;
      w_wrap_frame = 1'b0;
      if (w_advance) begin
         if (r_col == c_LAST_COL) begin
            w_col_nxt = 9'd0;
            if (r_row == c_LAST_ROW) begin
               w_row_nxt    = 9'd0;
               w_wrap_frame = 1'b1;
            end else begin
               w_row_nxt = r_row + 9'd1;
            end
         end else begin
            w_col_nxt = r_col + 9'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_gb         <= 8'd0;
         r_data       <= 4'd0;
         r_col        <= 9'd0;
         r_row        <= 9'd0;
         r_frame_done <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_data  <= w_data_nxt;
         r_col   <= w_col_nxt;
         r_row   <= w_row_nxt;
         if (w_accept) begin
            r_gb <= pix_rgb[7:0];
         end
         // A pulse raised just before a stall is kept pending and shown
         // once the stall releases, so it is never lost.
         if (!hold) begin
            r_frame_done <= w_wrap_frame;
         end
      end
   end

`ifdef PACKER_CHECKSUM_EN
   logic [15:0] r_acc;
   logic [15:0] r_checksum;
   logic [15:0] w_acc_sum;

   assign w_acc_sum = wr_en ? (r_acc + {12'd0, r_data}) : r_acc;
   assign checksum  = r_checksum;

   // The frame's last nibble is written on the wrap cycle, so the completed
   // sum lands in checksum at the same edge that raises frame_done.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc      <= 16'd0;
         r_checksum <= 16'd0;
      end else if (w_wrap_frame) begin
         r_acc      <= 16'd0;
         r_checksum <= w_acc_sum;
      end else begin
         r_acc <= w_acc_sum;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rgb_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_pixel_packer
// Purpose  : Self-checking bench for rgb_pixel_packer (WIDTH=4, HEIGHT=2).
//            The driver pushes expected nibbles into a queue as each pixel is
//            accepted; an independent monitor pops and compares them whenever
//            the DUT asserts wr_en.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_pixel_packer;

   localparam int W = 4;
   localparam int H = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        pix_valid;
   logic [11:0] pix_rgb;
   logic        pix_ready;
   logic        hold;
   logic        wr_en;
   logic [3:0]  data_out;
   logic [8:0]  col;
   logic [8:0]  row;
   logic        frame_done;
`ifdef PACKER_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   always #5 clk = ~clk;

   rgb_pixel_packer #(.WIDTH(W), .HEIGHT(H)) dut (
      .clk        (clk),
      .reset      (reset),
      .pix_valid  (pix_valid),
      .pix_rgb    (pix_rgb),
      .pix_ready  (pix_ready),
      .hold       (hold),
      .wr_en      (wr_en),
      .data_out   (data_out),
      .col        (col),
      .row        (row),
      .frame_done (frame_done)
`ifdef PACKER_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   typedef struct packed {
      logic [3:0]  d;
      logic [8:0]  c;
      logic [8:0]  r;
      logic        fd;
      logic [15:0] cks;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   int errors = 0;
   int checks = 0;

   // reference position / checksum model
   int          m_col, m_row;
   logic        m_pend_fd;
   logic [15:0] m_pend_cks;
   logic [15:0] m_sum;

   // contiguity measurement
   int cyc = 0;
   bit meas_en = 1'b0;
   int wr_cnt, first_cyc, last_cyc;

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic model_reset();
      m_col      = 0;
      m_row      = 0;
      m_pend_fd  = 1'b0;
      m_pend_cks = 16'd0;
      m_sum      = 16'd0;
   endtask

   // Push the three expected nibbles of an accepted pixel
   task automatic push_pixel(input logic [11:0] v);
      exp_t e;
      e.c   = 9'(m_col);
      e.r   = 9'(m_row);
      e.d   = v[11:8];
      e.fd  = m_pend_fd;
      e.cks = m_pend_cks;
      exp_q.push_back(e);
      m_pend_fd = 1'b0;
      e.fd  = 1'b0;
      e.cks = 16'd0;
      e.d   = v[7:4];
      exp_q.push_back(e);
      e.d   = v[3:0];
      exp_q.push_back(e);
      m_sum = m_sum + 16'(v[11:8]) + 16'(v[7:4]) + 16'(v[3:0]);
      if (m_col == W - 1) begin
         m_col = 0;
         if (m_row == H - 1) begin
            m_row      = 0;
            m_pend_fd  = 1'b1;
            m_pend_cks = m_sum;
            m_sum      = 16'd0;
         end else begin
            m_row = m_row + 1;
         end
      end else begin
         m_col = m_col + 1;
      end
   endtask

   // Present a pixel, wait (bounded) for acceptance, return just after the
   // accepting edge.
   task automatic send_pixel(input logic [11:0] v);
      bit ok = 1'b0;
      pix_valid = 1'b1;
      pix_rgb   = v;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (pix_ready === 1'b1) begin
            push_pixel(v);
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL accept_timeout: pixel %h not accepted, required acceptance within 40 cycles", v);
      end
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
   endtask

   task automatic reset_dut();
      reset     = 1'b1;
      pix_valid = 1'b0;
      hold      = 1'b0;
      pix_rgb   = 12'h000;
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
      model_reset();
      reset = 1'b0;
   endtask

   task automatic drain_check(input string name);
      repeat (5) @(posedge clk);
      #1;
      chk(name, 16'(exp_q.size()), 16'd0);
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      cyc++;
      if (wr_en === 1'b1) begin
         if (meas_en) begin
            wr_cnt++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_nibble: got data_out=%h col=%0d row=%0d, required no write", data_out, col, row);
         end else begin
            mon_e = exp_q.pop_front();
            if (data_out !== mon_e.d || col !== mon_e.c || row !== mon_e.r || frame_done !== mon_e.fd) begin
               errors++;
               $display("FAIL nibble: got d=%h col=%0d row=%0d fd=%b, required d=%h col=%0d row=%0d fd=%b",
                        data_out, col, row, frame_done, mon_e.d, mon_e.c, mon_e.r, mon_e.fd);
            end
`ifdef PACKER_CHECKSUM_EN
            if (mon_e.fd) begin
               checks++;
               if (checksum !== mon_e.cks) begin
                  errors++;
                  $display("FAIL checksum: got %h, required %h", checksum, mon_e.cks);
               end
            end
`endif
         end
      end else begin
         checks++;
         if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL idle_frame_done: got %b, required 0", frame_done);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      reset     = 1'b1;
      pix_valid = 1'b0;
      hold      = 1'b0;
      pix_rgb   = 12'h000;

      // ---- reset state ----
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_wr_en",      16'(wr_en),      16'd0);
      chk("rst_data_out",   16'(data_out),   16'd0);
      chk("rst_col",        16'(col),        16'd0);
      chk("rst_row",        16'(row),        16'd0);
      chk("rst_frame_done", 16'(frame_done), 16'd0);
      chk("rst_pix_ready",  16'(pix_ready),  16'd0);
`ifdef PACKER_CHECKSUM_EN
      chk("rst_checksum",   checksum,        16'd0);
`endif
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("idle_pix_ready", 16'(pix_ready), 16'd1);

      // ---- single pixel A5C ----
      reset_dut();
      send_pixel(12'hA5C);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("single_after_wr_en",     16'(wr_en),     16'd0);
      chk("single_after_pix_ready", 16'(pix_ready), 16'd1);
      chk("single_after_data_hold", 16'(data_out),  16'hC);
      drain_check("single_drain");

      // ---- streaming frame plus one pixel across the boundary ----
      reset_dut();
      wr_cnt    = 0;
      first_cyc = -1;
      last_cyc  = -1;
      meas_en   = 1'b1;
      for (int k = 0; k < 9; k++) begin
         send_pixel(12'(k));
      end
      repeat (5) @(posedge clk);
      #1;
      meas_en = 1'b0;
      chk("stream_wr_count",  16'(wr_cnt),                   16'd27);
      chk("stream_contig",    16'(last_cyc - first_cyc + 1), 16'd27);
      chk("stream_drain",     16'(exp_q.size()),             16'd0);

      // ---- hold for 5 cycles starting on the G nibble of 3E7 ----
      reset_dut();
      send_pixel(12'h3E7);            // now in SEND_R cycle
      @(posedge clk);
      #1;                             // now in SEND_G cycle
      hold = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold_wr_en",     16'(wr_en),     16'd0);
         chk("hold_data_out",  16'(data_out),  16'hE);
         chk("hold_pix_ready", 16'(pix_ready), 16'd0);
         @(posedge clk);
         #1;
      end
      hold = 1'b0;
      drain_check("hold_drain");

      // ---- reset during SEND_G of 9F1 at row 1, col 2 ----
      reset_dut();
      for (int k = 0; k < 6; k++) begin
         send_pixel(12'h111 * 12'(k));
      end
      send_pixel(12'h9F1);            // SEND_R of 9F1
      @(posedge clk);
      #1;                             // SEND_G of 9F1
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_pix_ready", 16'(pix_ready), 16'd0);
      @(posedge clk);
      #1;
      exp_q.delete();
      model_reset();
      @(negedge clk);
      chk("rst_mid_wr_en",    16'(wr_en),    16'd0);
      chk("rst_mid_col",      16'(col),      16'd0);
      chk("rst_mid_row",      16'(row),      16'd0);
      chk("rst_mid_data_out", 16'(data_out), 16'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      send_pixel(12'h4B2);
      drain_check("rst_mid_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
